cdb_rr_arbiter: RTL

Parametrised successor to the fixed-priority CDB arbiter. Selects one of `N_REQ` reservation-station/functional-unit CDB requests per cycle and drives the registered common data bus. It adds a selectable round-robin or aged fixed-priority policy, a downstream stall input, and a pipeline-flush input. It sits between the reservation stations and the CDB consumers (ROB, register file, RS operand capture).

---
 rtl/cdb_rr_arbiter_if.sv | 43 ++++
 rtl/cdb_rr_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cdb_rr_arbiter_if.sv
// CDB payload type and the arbiter bus interface.
// The arbiter drives the master side; the requesters and consumers sit on the slave side.
package cdb_rr_pkg;
    // One common-data-bus broadcast: valid flag, ROB tag and result value.
    typedef struct packed {
        logic        valid;
        logic [5:0]  tag;
        logic [31:0] value;
    } CDB;
endpackage

interface cdb_rr_arbiter_if
    import cdb_rr_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    CDB               RS_CDB_in [0:N_REQ-1];
    logic             stall;
    logic             flush;
    logic             RS_flush  [0:N_REQ-1];
    CDB               CDB_out;
    logic [IDX_W-1:0] grant_idx;

    modport master (
        input  RS_CDB_in,
        input  stall,
        input  flush,
        output RS_flush,
        output CDB_out,
        output grant_idx
    );

    modport slave (
        output RS_CDB_in,
        output stall,
        output flush,
        input  RS_flush,
        input  CDB_out,
        input  grant_idx
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// CDB arbiter: picks one requester per unstalled cycle, using either a
// round-robin pointer or fixed priority with age-based promotion, and
// registers the winner's broadcast onto the common data bus.
module cdb_rr_arbiter
    import cdb_rr_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MODE      = 1,
    parameter int AGE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    cdb_rr_arbiter_if.master bus
);
    localparam int          IDX_W    = $clog2(N_REQ);
    localparam int unsigned N_U      = N_REQ;
    localparam logic [7:0]  AGE_LIM8 = 8'(AGE_LIMIT);

    logic [N_REQ-1:0] req_valid;
    logic             any_req;
    logic             grant;
    logic [IDX_W-1:0] winner;

    // Collect the per-requester valid bits.
    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            req_valid[i] = bus.RS_CDB_in[i].valid;
        end
    end

    assign any_req = |req_valid;
    // Flush outranks stall; both block the grant, as does reset.
    assign grant   = !rst && !bus.flush && !bus.stall && any_req;

    if (MODE == 1) begin : g_rr
        logic [IDX_W-1:0] ptr;
        logic [IDX_W-1:0] rr_pick;
        logic             rr_found;
        int unsigned      idx;

        // Search from ptr upward, wrapping explicitly at N_REQ.
        always_comb begin
            rr_pick  = '0;
            rr_found = 1'b0;
            idx      = 0;
            for (int unsigned k = 0; k < N_U; k++) begin
                idx = k + {{(32-IDX_W){1'b0}}, ptr};
                if (idx >= N_U) begin
                    idx = idx - N_U;
                end
                if (!rr_found && req_valid[idx[IDX_W-1:0]]) begin
                    rr_pick  = idx[IDX_W-1:0];
                    rr_found = 1'b1;
                end
            end
        end

        assign winner = rr_pick;

        // Pointer moves just past the winner; flush returns it to 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ptr <= '0;
            end else if (bus.flush) begin
                ptr <= '0;
            end else if (grant) begin
                ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end else begin : g_fixed
        logic [7:0]       age [N_REQ];
        logic [N_REQ-1:0] aged;
        logic [IDX_W-1:0] fx_pick;
        logic             fx_found;

        // A requester is promoted once it has waited AGE_LIMIT cycles.
        always_comb begin
            aged = '0;
            for (int unsigned i = 0; i < N_U; i++) begin
                aged[i] = req_valid[i] && (age[i] >= AGE_LIM8);
            end
        end

        // Lowest-index aged requester first, otherwise lowest-index valid.
        always_comb begin
            fx_pick  = '0;
            fx_found = 1'b0;
            for (int unsigned i = 0; i < N_U; i++) begin
                if (!fx_found && aged[i]) begin
                    fx_pick  = IDX_W'(i);
                    fx_found = 1'b1;
                end
            end
            for (int unsigned i = 0; i < N_U; i++) begin
                if (!fx_found && req_valid[i]) begin
                    fx_pick  = IDX_W'(i);
                    fx_found = 1'b1;
                end
            end
        end

        assign winner = fx_pick;

        // Saturating wait counters; stall freezes them, flush clears them.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned i = 0; i < N_U; i++) begin
                    age[i] <= '0;
                end
            end else if (bus.flush) begin
                for (int unsigned i = 0; i < N_U; i++) begin
                    age[i] <= '0;
                end
            end else if (!bus.stall) begin
                for (int unsigned i = 0; i < N_U; i++) begin
                    if (!req_valid[i] || (grant && winner == IDX_W'(i))) begin
                        age[i] <= '0;
                    end else if (age[i] != '1) begin
                        age[i] <= age[i] + 8'd1;
                    end
                end
            end
        end
    end

    // One-hot grant pulse and winner index, zero when nothing is granted.
    always_comb begin
        for (int unsigned i = 0; i < N_U; i++) begin
            bus.RS_flush[i] = grant && (winner == IDX_W'(i));
        end
        bus.grant_idx = grant ? winner : '0;
    end

    // Registered broadcast: load winner, hold under stall, otherwise clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.CDB_out <= '0;
        end else if (grant) begin
            bus.CDB_out <= bus.RS_CDB_in[winner];
        end else if (bus.flush || !bus.stall) begin
            bus.CDB_out <= '0;
        end
    end
endmodule
